// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - request, status and uart_tx handshake bundle for uart_tx_scheduler
interface uart_tx_scheduler_if;
  logic       echo_valid;
  logic [7:0] echo_data;
  logic       result_valid;
  logic [3:0] result_label;
  logic       tx_done_tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       echo_full;
  logic       result_ready;
  logic       echo_overflow;
  logic       result_overflow;

  modport master (
    output echo_valid, echo_data, result_valid, result_label, tx_done_tick,
    input  tx_start, tx_data, busy, echo_full, result_ready, echo_overflow, result_overflow
  );

  modport slave (
    input  echo_valid, echo_data, result_valid, result_label, tx_done_tick,
    output tx_start, tx_data, busy, echo_full, result_ready, echo_overflow, result_overflow
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one uart_tx between buffered echo bytes and 3-byte result messages
module uart_tx_scheduler #(
  parameter int ECHO_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int AW = (ECHO_DEPTH > 1) ? $clog2(ECHO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(ECHO_DEPTH);
  localparam logic GRANT_ECHO   = 1'b0;
  localparam logic GRANT_RESULT = 1'b1;

  typedef enum logic [1:0] {ARB, SEND, WAIT} state_t;

  state_t        state;
  logic [7:0]    mem [ECHO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          last_grant;
  logic [1:0]    byte_idx;
  logic [3:0]    label;
  logic          result_pending;

  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          busy_q;
  logic          echo_full_q;
  logic          result_ready_q;
  logic          echo_ovf_q;
  logic          result_ovf_q;

  logic          grant_echo;
  logic          grant_result;
  logic          push;

  function automatic logic [7:0] msg_byte(input logic [3:0] lbl, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = (lbl <= 4'd9) ? (8'h30 + {4'h0, lbl}) : 8'h3F;
      2'd1:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  // Round robin only matters on a tie; otherwise the single pending source wins.
  always_comb begin
    grant_echo   = 1'b0;
    grant_result = 1'b0;
    if (state == ARB) begin
      if ((count != '0) && result_pending) begin
        grant_echo   = (last_grant == GRANT_RESULT);
        grant_result = (last_grant == GRANT_ECHO);
      end else begin
        grant_echo   = (count != '0);
        grant_result = result_pending;
      end
    end
    push       = bus.echo_valid && ((count != FULL_COUNT) || grant_echo);
    count_next = count + CW'(push) - CW'(grant_echo);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARB;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      last_grant     <= GRANT_RESULT;
      byte_idx       <= '0;
      label          <= '0;
      result_pending <= 1'b0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      busy_q         <= 1'b0;
      echo_full_q    <= 1'b0;
      result_ready_q <= 1'b1;
      echo_ovf_q     <= 1'b0;
      result_ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.echo_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (grant_echo) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count       <= count_next;
      echo_full_q <= (count_next == FULL_COUNT);
      if (bus.echo_valid && !push) begin
        echo_ovf_q <= 1'b1;
      end

      // The slot stays owned until the LF completes, so a strobe during the message is dropped.
      if (bus.result_valid) begin
        if (result_ready_q) begin
          label          <= bus.result_label;
          result_pending <= 1'b1;
          result_ready_q <= 1'b0;
        end else begin
          result_ovf_q <= 1'b1;
        end
      end

      case (state)
        ARB: begin
          if (grant_echo) begin
            tx_data_q  <= mem[rd_ptr];
            last_grant <= GRANT_ECHO;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= SEND;
          end else if (grant_result) begin
            tx_data_q      <= msg_byte(label, 2'd0);
            byte_idx       <= 2'd0;
            result_pending <= 1'b0;
            last_grant     <= GRANT_RESULT;
            tx_start_q     <= 1'b1;
            busy_q         <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          tx_start_q <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (bus.tx_done_tick) begin
            if ((last_grant == GRANT_ECHO) || (byte_idx == 2'd2)) begin
              if (last_grant == GRANT_RESULT) begin
                result_ready_q <= 1'b1;
              end
              busy_q <= 1'b0;
              state  <= ARB;
            end else begin
              byte_idx   <= byte_idx + 2'd1;
              tx_data_q  <= msg_byte(label, byte_idx + 2'd1);
              tx_start_q <= 1'b1;
              state      <= SEND;
            end
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= ARB;
        end
      endcase
    end
  end

  assign bus.tx_start        = tx_start_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.busy            = busy_q;
  assign bus.echo_full       = echo_full_q;
  assign bus.result_ready    = result_ready_q;
  assign bus.echo_overflow   = echo_ovf_q;
  assign bus.result_overflow = result_ovf_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [7:0] sb [$];
  logic [7:0] last_exp;
  int n_starts;

  uart_tx_scheduler_if ifc ();

  uart_tx_scheduler #(.ECHO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic pulse_echo(input logic [7:0] b);
    ifc.echo_valid = 1'b1;
    ifc.echo_data  = b;
    tick();
    ifc.echo_valid = 1'b0;
  endtask

  task automatic pulse_result(input logic [3:0] l);
    ifc.result_valid = 1'b1;
    ifc.result_label = l;
    tick();
    ifc.result_valid = 1'b0;
  endtask

  task automatic pulse_done();
    ifc.tx_done_tick = 1'b1;
    tick();
    ifc.tx_done_tick = 1'b0;
  endtask

  task automatic expect_start(input string tag, input int lat);
    int n;
    logic [7:0] exp;
    n = 0;
    while (ifc.tx_start !== 1'b1 && n < 32) begin
      tick();
      n++;
    end
    check_int({tag, " latency"}, n, lat);
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = 'x;
    check_byte({tag, " data"}, ifc.tx_data, exp);
    last_exp = exp;
  endtask

  task automatic finish_byte(input string tag);
    tick();
    check_bit({tag, " strobe width"}, ifc.tx_start, 1'b0);
    tick();
    tick();
    check_byte({tag, " held"}, ifc.tx_data, last_exp);
    pulse_done();
  endtask

  task automatic count_starts(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (ifc.tx_start === 1'b1) n++;
      tick();
    end
  endtask

  initial begin
    ifc.echo_valid   = 1'b0;
    ifc.echo_data    = '0;
    ifc.result_valid = 1'b0;
    ifc.result_label = '0;
    ifc.tx_done_tick = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check_bit("reset tx_start", ifc.tx_start, 1'b0);
    check_byte("reset tx_data", ifc.tx_data, 8'h00);
    check_bit("reset busy", ifc.busy, 1'b0);
    check_bit("reset echo_full", ifc.echo_full, 1'b0);
    check_bit("reset result_ready", ifc.result_ready, 1'b1);
    check_bit("reset echo_overflow", ifc.echo_overflow, 1'b0);
    check_bit("reset result_overflow", ifc.result_overflow, 1'b0);

    // single echo
    sb.push_back(8'h41);
    pulse_echo(8'h41);
    expect_start("t1 echo", 1);
    check_bit("t1 busy", ifc.busy, 1'b1);
    finish_byte("t1 echo");
    check_bit("t1 idle", ifc.busy, 1'b0);

    // result message
    sb.push_back(8'h37); sb.push_back(8'h0D); sb.push_back(8'h0A);
    pulse_result(4'd7);
    check_bit("t2 ready low", ifc.result_ready, 1'b0);
    expect_start("t2 digit", 1);
    finish_byte("t2 digit");
    expect_start("t2 cr", 0);
    check_bit("t2 ready mid", ifc.result_ready, 1'b0);
    finish_byte("t2 cr");
    expect_start("t2 lf", 0);
    finish_byte("t2 lf");
    check_bit("t2 ready back", ifc.result_ready, 1'b1);
    check_bit("t2 idle", ifc.busy, 1'b0);

    // contention after reset
    do_reset();
    sb.push_back(8'h31); sb.push_back(8'h33); sb.push_back(8'h0D); sb.push_back(8'h0A);
    ifc.echo_valid   = 1'b1;
    ifc.echo_data    = 8'h31;
    ifc.result_valid = 1'b1;
    ifc.result_label = 4'd3;
    tick();
    ifc.echo_valid   = 1'b0;
    ifc.result_valid = 1'b0;
    expect_start("t3 echo first", 1);
    finish_byte("t3 echo");
    expect_start("t3 digit", 1);
    sb.push_back(8'h32);
    pulse_echo(8'h32);
    finish_byte("t3 digit");
    expect_start("t3 cr", 0);
    finish_byte("t3 cr");
    expect_start("t3 lf", 0);
    finish_byte("t3 lf");
    expect_start("t3 late echo", 1);
    finish_byte("t3 late echo");

    // overflow of both sources
    do_reset();
    sb.push_back(8'h35); sb.push_back(8'h0D); sb.push_back(8'h0A);
    pulse_result(4'd5);
    pulse_result(4'd9);
    check_bit("t4 result_overflow", ifc.result_overflow, 1'b1);
    expect_start("t4 digit", 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb.push_back(8'(8'h10 + i));
      pulse_echo(8'(8'h10 + i));
      if (i == 3) begin
        check_bit("t4 full", ifc.echo_full, 1'b1);
        check_bit("t4 no overflow yet", ifc.echo_overflow, 1'b0);
      end
    end
    check_bit("t4 echo_overflow", ifc.echo_overflow, 1'b1);
    finish_byte("t4 digit");
    expect_start("t4 cr", 0);
    finish_byte("t4 cr");
    expect_start("t4 lf", 0);
    finish_byte("t4 lf");
    for (int i = 0; i < 4; i++) begin
      expect_start("t4 echo", 1);
      finish_byte("t4 echo");
    end
    check_bit("t4 idle", ifc.busy, 1'b0);
    count_starts(6, n_starts);
    check_int("t4 dropped byte absent", n_starts, 0);
    check_int("t4 scoreboard drained", sb.size(), 0);
    check_bit("t4 overflow sticky", ifc.echo_overflow, 1'b1);

    // boundaries: out-of-range label, push+pop while full
    do_reset();
    sb.push_back(8'h3F); sb.push_back(8'h0D); sb.push_back(8'h0A);
    pulse_result(4'd12);
    expect_start("t5 label12", 1);
    finish_byte("t5 label12");
    expect_start("t5 cr", 0);
    finish_byte("t5 cr");
    expect_start("t5 lf", 0);
    finish_byte("t5 lf");
    sb.push_back(8'h31); sb.push_back(8'h0D); sb.push_back(8'h0A);
    pulse_result(4'd1);
    expect_start("t5 digit1", 1);
    for (int i = 0; i < 4; i++) begin
      sb.push_back(8'(8'h20 + i));
      pulse_echo(8'(8'h20 + i));
    end
    check_bit("t5 full", ifc.echo_full, 1'b1);
    finish_byte("t5 digit1");
    expect_start("t5 cr1", 0);
    finish_byte("t5 cr1");
    expect_start("t5 lf1", 0);
    finish_byte("t5 lf1");
    sb.push_back(8'h24);
    pulse_echo(8'h24);
    check_bit("t5 push-pop no overflow", ifc.echo_overflow, 1'b0);
    check_bit("t5 push-pop still full", ifc.echo_full, 1'b1);
    expect_start("t5 pop", 0);
    finish_byte("t5 pop");
    for (int i = 0; i < 4; i++) begin
      expect_start("t5 echo", 1);
      finish_byte("t5 echo");
    end
    check_bit("t5 overflow clear", ifc.echo_overflow, 1'b0);
    check_bit("t5 empty", ifc.echo_full, 1'b0);

    // reset while waiting on CR
    do_reset();
    sb.push_back(8'h34); sb.push_back(8'h0D); sb.push_back(8'h0A);
    pulse_result(4'd4);
    expect_start("t6 digit", 1);
    sb.push_back(8'h55);
    pulse_echo(8'h55);
    finish_byte("t6 digit");
    expect_start("t6 cr", 0);
    tick();
    do_reset();
    check_bit("t6 busy", ifc.busy, 1'b0);
    check_bit("t6 ready", ifc.result_ready, 1'b1);
    check_bit("t6 echo_full", ifc.echo_full, 1'b0);
    check_bit("t6 tx_start", ifc.tx_start, 1'b0);
    pulse_done();
    count_starts(8, n_starts);
    check_int("t6 stray done ignored", n_starts, 0);
    sb.push_back(8'h7E);
    pulse_echo(8'h7E);
    expect_start("t6 after reset", 1);
    finish_byte("t6 after reset");
    check_int("t6 scoreboard drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
